// File: rtl/nibble_serial_adder_ctrl_if.sv
// Request-side bundle for nibble_serial_adder_ctrl: operands, start and
// result/status. The master is the requesting control unit and the slave is
// the sequencer. The optional subtract select exists only when ADD_SUB_EN is
// defined.
interface nibble_serial_adder_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
`ifdef ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;

`ifdef ADD_SUB_EN
  modport master (output start, a, b, c_in, sub, input busy, done, sum, c_out);
  modport slave  (input start, a, b, c_in, sub, output busy, done, sum, c_out);
`else
  modport master (output start, a, b, c_in, input busy, done, sum, c_out);
  modport slave  (input start, a, b, c_in, output busy, done, sum, c_out);
`endif
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: performs WIDTH-bit additions by driving one
// external 4-bit ripple adder a nibble per clock, least-significant first.
// The adder is purely combinational outside this block; its result is
// captured on the same edge that advances the nibble index.
// Optional feature macro: ADD_SUB_EN (adds the sub select; subtraction is
// done as A + ~B + 1 using the same adder).
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  nibble_serial_adder_ctrl_if.slave  req,
  output logic [3:0]                 add_a_o,
  output logic [3:0]                 add_b_o,
  output logic                       add_cin_o,
  input  logic [3:0]                 add_sum_i,
  input  logic                       add_cout_i
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  // Reject illegal widths at elaboration time.
  if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_bad_width
    $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IDXW-1:0]  idx_q;
  logic             cr_q;
  logic [WIDTH-1:0] sum_q;
  logic             c_out_q;
  logic             busy_q;
  logic             done_q;
`ifdef ADD_SUB_EN
  logic             sub_q;
`endif

  logic [IDXW+1:0]  bit_base_s;
  logic [3:0]       b_nib_s;
  logic [IDXW-1:0]  idx_d;

  // Bit offset of the current nibble and the incremented index.
  assign bit_base_s = {idx_q, 2'b00};
  assign idx_d      = idx_q + IDXW'(1);
  assign b_nib_s    = b_q[bit_base_s +: 4];

  assign req.busy  = busy_q;
  assign req.done  = done_q;
  assign req.sum   = sum_q;
  assign req.c_out = c_out_q;

  // Adder operand drive: the current nibble while running, zero otherwise.
  always_comb begin
    add_a_o   = 4'd0;
    add_b_o   = 4'd0;
    add_cin_o = 1'b0;
    if (state_q == ST_RUN) begin
      add_a_o   = a_q[bit_base_s +: 4];
`ifdef ADD_SUB_EN
      add_b_o   = sub_q ? ~b_nib_s : b_nib_s;
`else
      add_b_o   = b_nib_s;
`endif
      add_cin_o = cr_q;
    end else begin
      add_a_o   = 4'd0;
      add_b_o   = 4'd0;
      add_cin_o = 1'b0;
    end
  end

  // Sequencer FSM: accept a request, step through the nibbles, pulse done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      idx_q   <= {IDXW{1'b0}};
      cr_q    <= 1'b0;
      sum_q   <= {WIDTH{1'b0}};
      c_out_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (req.start) begin
            a_q    <= req.a;
            b_q    <= req.b;
            idx_q  <= {IDXW{1'b0}};
`ifdef ADD_SUB_EN
            sub_q  <= req.sub;
            // Two's-complement subtract needs the +1 on the first nibble.
            cr_q   <= req.sub ? 1'b1 : req.c_in;
`else
            cr_q   <= req.c_in;
`endif
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          sum_q[bit_base_s +: 4] <= add_sum_i;
          cr_q                   <= add_cout_i;
          if (idx_q == LAST_IDX) begin
            idx_q   <= {IDXW{1'b0}};
            c_out_q <= add_cout_i;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            idx_q   <= idx_d;
            state_q <= ST_RUN;
          end
        end
        ST_DONE: begin
          // A start seen here is deliberately dropped, not queued.
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          idx_q   <= {IDXW{1'b0}};
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl (WIDTH=16). A behavioural
// 4-bit adder closes the loop; expected results go into a scoreboard queue
// when a request is issued and are compared when done pulses.
module tb_nibble_serial_adder_ctrl;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic       clk;
  logic       rst;
  logic [3:0] add_a;
  logic [3:0] add_b;
  logic       add_cin;
  logic [3:0] add_sum;
  logic       add_cout;

  int checks = 0;
  int errors = 0;

  logic [W:0] sb_q[$];
  logic       cin_log[NIB];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         sb;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  vec_t vecs[$];

  nibble_serial_adder_ctrl_if #(.WIDTH(W)) ifc ();

  nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (ifc),
    .add_a_o    (add_a),
    .add_b_o    (add_b),
    .add_cin_o  (add_cin),
    .add_sum_i  (add_sum),
    .add_cout_i (add_cout)
  );

  // External 4-bit ripple adder model.
  logic [4:0] adder_res;
  assign adder_res = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
  assign add_sum   = adder_res[3:0];
  assign add_cout  = adder_res[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_req(input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic ci, input logic sb);
    ifc.start = 1'b1;
    ifc.a     = av;
    ifc.b     = bv;
    ifc.c_in  = ci;
`ifdef ADD_SUB_EN
    ifc.sub   = sb;
`else
    if (sb) $display("note: subtract vector issued without ADD_SUB_EN");
`endif
  endtask

  // Pop the oldest expected result and compare it with the DUT outputs.
  task automatic check_result(input string nm);
    logic [W:0] e;
    if (sb_q.size() == 0) begin
      chk({nm, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({nm, "_sum"}, {16'd0, ifc.sum}, {16'd0, e[W-1:0]});
      chk({nm, "_cout"}, {31'd0, ifc.c_out}, {31'd0, e[W]});
    end
  endtask

  // One complete operation with timing checks; a/b are scrambled while busy.
  task automatic run_op(input vec_t v, input string nm);
    int  cyc;
    int  busy_cnt;
    bit  got;
    @(negedge clk);
    drive_req(v.a, v.b, v.ci, v.sb);
    sb_q.push_back({v.exp_cout, v.exp_sum});
    @(negedge clk);
    ifc.start = 1'b0;
    cyc = 1; busy_cnt = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      if (ifc.done === 1'b1) begin
        got = 1'b1;
      end else begin
        if (ifc.busy === 1'b1) begin
          if (busy_cnt < NIB) cin_log[busy_cnt] = add_cin;
          busy_cnt++;
        end
        ifc.a = W'($urandom);
        ifc.b = W'($urandom);
        @(negedge clk);
        cyc++;
      end
    end
    if (!got) begin
      chk({nm, "_done_timeout"}, 32'd1, 32'd0);
    end else begin
      chk({nm, "_done_cycle"}, cyc, NIB + 1);
      chk({nm, "_busy_cycles"}, busy_cnt, NIB);
      chk({nm, "_idle_adder"}, {23'd0, add_a, add_b, add_cin}, 32'd0);
      check_result(nm);
      @(negedge clk);
      chk({nm, "_done_pulse"}, {31'd0, ifc.done}, 32'd0);
    end
  endtask

  initial begin
    int  done_seen;
    bit  got;
    rst       = 1'b1;
    ifc.start = 1'b0;
    ifc.a     = '0;
    ifc.b     = '0;
    ifc.c_in  = 1'b0;
`ifdef ADD_SUB_EN
    ifc.sub   = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_busy",  {31'd0, ifc.busy}, 32'd0);
    chk("rst_done",  {31'd0, ifc.done}, 32'd0);
    chk("rst_sum",   {16'd0, ifc.sum}, 32'd0);
    chk("rst_cout",  {31'd0, ifc.c_out}, 32'd0);
    chk("rst_add_a", {28'd0, add_a}, 32'd0);
    chk("rst_add_b", {28'd0, add_b}, 32'd0);
    chk("rst_cin",   {31'd0, add_cin}, 32'd0);
    rst = 1'b0;

    // Vector table: a, b, c_in, sub, expected sum, expected c_out.
    vecs.push_back('{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'h0F0F, 16'h00F0, 1'b1, 1'b0, 16'h1000, 1'b0});
    vecs.push_back('{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'hABCD, 16'h1234, 1'b0, 1'b0, 16'hBE01, 1'b0});
`ifdef ADD_SUB_EN
    vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0});
    vecs.push_back('{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1});
    vecs.push_back('{16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0});
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
      if (vecs[i].a == 16'hFFFF && vecs[i].b == 16'h0001 && !vecs[i].sb) begin
        // Carry ripples through every nibble boundary.
        chk("carry_n0", {31'd0, cin_log[0]}, 32'd0);
        chk("carry_n1", {31'd0, cin_log[1]}, 32'd1);
        chk("carry_n2", {31'd0, cin_log[2]}, 32'd1);
        chk("carry_n3", {31'd0, cin_log[3]}, 32'd1);
      end
    end

    // Start held high and operands changed through RUN and DONE.
    @(negedge clk);
    drive_req(16'h1234, 16'h4321, 1'b0, 1'b0);
    sb_q.push_back({1'b0, 16'h5555});
    for (int cyc = 1; cyc <= NIB + 1; cyc++) begin
      @(negedge clk);
      if (cyc <= NIB) begin
        chk($sformatf("hold_busy_c%0d", cyc), {31'd0, ifc.busy}, 32'd1);
        chk($sformatf("hold_done_c%0d", cyc), {31'd0, ifc.done}, 32'd0);
      end else begin
        chk("hold_done", {31'd0, ifc.done}, 32'd1);
        chk("hold_busy_in_done", {31'd0, ifc.busy}, 32'd0);
        check_result("hold");
      end
      ifc.a = W'($urandom);
      ifc.b = W'($urandom);
    end
    @(negedge clk);
    chk("hold_idle_busy", {31'd0, ifc.busy}, 32'd0);
    chk("hold_idle_done", {31'd0, ifc.done}, 32'd0);
    drive_req(16'h0001, 16'h0002, 1'b0, 1'b0);
    sb_q.push_back({1'b0, 16'h0003});
    @(negedge clk);
    chk("hold_restart_busy", {31'd0, ifc.busy}, 32'd1);
    ifc.start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (ifc.done === 1'b1) begin
        got = 1'b1;
        check_result("hold_second");
      end
    end
    if (!got) chk("hold_second_timeout", 32'd1, 32'd0);
    @(negedge clk);

    // Reset in the second RUN cycle discards the operation.
    @(negedge clk);
    drive_req(16'h1234, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    ifc.start = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy_before", {31'd0, ifc.busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", {31'd0, ifc.busy}, 32'd0);
    chk("mid_rst_done", {31'd0, ifc.done}, 32'd0);
    chk("mid_rst_sum",  {16'd0, ifc.sum}, 32'd0);
    chk("mid_rst_cout", {31'd0, ifc.c_out}, 32'd0);
    chk("mid_rst_add",  {23'd0, add_a, add_b, add_cin}, 32'd0);
    rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < NIB + 4; k++) begin
      @(negedge clk);
      if (ifc.done === 1'b1) done_seen++;
    end
    chk("mid_rst_no_done", done_seen, 0);
    chk("sb_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Sequencer that performs WIDTH-bit additions by time-multiplexing one external 4-bit ripple adder, one nibble per clock, least-significant nibble first. It accepts a start pulse with operands, drives the adder's a/b/carry-in each cycle, captures sum and carry-out, and reports a registered WIDTH-bit result with a one-cycle done pulse. It sits between a requesting control unit and the team's 4-bit adder datapath, so wide adds cost no extra adder area.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4. NIB = WIDTH/4.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A; latched on accepted start.
- b  in  WIDTH  operand B; latched on accepted start.
- c_in  in  1  carry into nibble 0; latched on accepted start.
- sub  in  1  subtract select; present only with ADD_SUB_EN.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse in DONE.
- sum  out  WIDTH  registered result; held until the next accepted start.
- c_out  out  1  carry out of the top nibble; held with sum.
- add_a  out  4  to adder a: current nibble of latched A.
- add_b  out  4  to adder b: current nibble of latched B (or ~B, see Configuration).
- add_cin  out  1  to adder carry-in.
- add_sum  in  4  from adder sum (combinational, same cycle).
- add_cout  in  1  from adder carry-out (combinational, same cycle).

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- IDLE: start=1 -> latch a, b, c_in (and sub), clear nibble index idx to 0, carry register cr <= c_in, go RUN. start=0 -> stay.
- RUN: add_a = A[4*idx+3:4*idx], add_b = B nibble idx, add_cin = cr. On each edge: sum nibble idx <= add_sum, cr <= add_cout, idx <= idx+1. When idx = NIB-1: c_out <= add_cout, go DONE.
- DONE: done=1 for exactly one cycle, then IDLE. start in DONE is ignored (not queued).
- start while busy ignored; latched operands do not change mid-operation, input changes on a/b have no effect.
- sum/c_out are written nibble-by-nibble during RUN; only valid when done=1 and afterwards until the next accepted start.
- Outside RUN: add_a, add_b, add_cin drive 0.
- idx counter width is clog2(NIB), minimum 1 bit; no wrap beyond NIB-1 occurs.
- WIDTH=4: RUN lasts exactly one cycle.
- rst in any state: IDLE, idx=0, cr=0, sum=0, c_out=0, busy=0, done=0; operation in flight is discarded with no done pulse.

## Timing
- Reset values: busy=0, done=0, sum=0, c_out=0, add_a=0, add_b=0, add_cin=0.
- start sampled high at edge 0 -> busy high cycles 1..NIB -> done high in cycle NIB+1 -> IDLE at cycle NIB+2.
- Latency start-to-done: NIB+1 clocks; throughput one operation per NIB+2 clocks.
- The adder path (add_* out -> adder -> add_sum/add_cout in -> registers) must close within one clock.

## Configuration
- ADD_SUB_EN defined: sub port exists. When latched sub=1, add_b = ~B nibble and cr initialised to 1 (c_in ignored); result = A - B mod 2^WIDTH, c_out=1 means no borrow. sub=0 behaves as plain add.
- ADD_SUB_EN undefined: no sub port; add_b always the true B nibble; add only.

## Test plan
- WIDTH=16, a=0x1234, b=0x1111, c_in=0, start one cycle -> busy 4 cycles, done in cycle 5, sum=0x2345, c_out=0.
- a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1; carry observed propagating through all four nibbles on add_cin.
- a=0x0F0F, b=0x00F0, c_in=1 -> sum=0x1000, c_out=0.
- Start accepted, then start held high and a/b changed during RUN and DONE -> single done pulse, result from original operands, next operation starts only after return to IDLE.
- rst asserted in cycle 2 of RUN -> next cycle busy=0, done=0, sum=0, c_out=0; no done pulse follows.
- ADD_SUB_EN: sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, c_out=0; a=0x0007, b=0x0005 -> sum=0x0002, c_out=1.
